sn76489_bus_writer: RTL and testbench



---
 rtl/sn76489_bus_writer.sv | 174 +++++++++++++++++
 tb/tb_sn76489_bus_writer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sn76489_bus_writer.sv
// SN76489 host-side bus writer: turns register updates into latch/data
// bytes driven with CE/WE strobes and paced by the chip's READY line.
module sn76489_bus_writer #(
   parameter int SETUP_CYCLES   = 1,
   parameter int STROBE_MIN     = 4,
   parameter int HOLD_CYCLES    = 1,
   parameter int TIMEOUT        = 64,
   parameter bit SKIP_UNCHANGED = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] in_reg,
   input  logic [9:0] in_value,
   output logic [7:0] psg_data,
   output logic       psg_ce_n,
   output logic       psg_we_n,
   input  logic       psg_ready,
   output logic       busy,
   output logic       done,
   output logic       timeout_err,
   input  logic       err_clr
);

   localparam int MAX_A = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int MAX_B = (STROBE_MIN > TIMEOUT) ? STROBE_MIN : TIMEOUT;
   localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW    = $clog2(MAXP + 1);

   localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYCLES);
   localparam logic [CW-1:0] C_SMIN  = CW'(STROBE_MIN);
   localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] C_TO    = CW'(TIMEOUT);
   localparam logic [CW-1:0] C_ONE   = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [7:0]    r_data;
   logic [7:0]    r_dbyte;
   logic          r_pend;
   logic          r_phase;
   logic [1:0]    r_idx;
   logic [5:0]    r_sh [4];
   logic [3:0]    r_sv;
   logic          r_rdy_m;
   logic          r_rdy_s;
   logic          r_ce_n;
   logic          r_we_n;
   logic          r_in_ready;
   logic          r_busy;
   logic          r_done;
   logic          r_err;

   logic          w_tone;
   logic [1:0]    w_idx;
   logic          w_skip;
   logic [7:0]    w_latch;
   logic          w_strobe_ok;
   logic          w_to;

   // Tone registers are the even ones except the noise control (reg 6).
   assign w_tone  = ~in_reg[0] & (in_reg != 3'd6);
   assign w_idx   = in_reg[2:1];
   assign w_skip  = SKIP_UNCHANGED && w_tone && r_sv[w_idx]
                    && (r_sh[w_idx] == in_value[9:4]);
   assign w_latch = (in_reg == 3'd6) ? {5'b11100, in_value[2:0]}
                                     : {1'b1, in_reg, in_value[3:0]};

   assign w_strobe_ok = (r_cnt >= C_SMIN) && r_rdy_s;
   assign w_to        = (r_cnt == C_TO);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_data     <= 8'h00;
         r_dbyte    <= 8'h00;
         r_pend     <= 1'b0;
         r_phase    <= 1'b0;
         r_idx      <= 2'd0;
         r_sv       <= 4'h0;
         for (int i = 0; i < 4; i++) r_sh[i] <= 6'h00;
         r_rdy_m    <= 1'b0;
         r_rdy_s    <= 1'b0;
         r_ce_n     <= 1'b1;
         r_we_n     <= 1'b1;
         r_in_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_rdy_m <= psg_ready;
         r_rdy_s <= r_rdy_m;
         r_done  <= 1'b0;
         if (err_clr) r_err <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_data     <= w_latch;
                  r_dbyte    <= {2'b00, in_value[9:4]};
                  r_pend     <= w_tone & ~w_skip;
                  r_phase    <= 1'b0;
                  r_idx      <= w_idx;
                  r_ce_n     <= 1'b0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_cnt      <= C_ONE;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt >= C_SETUP) begin
                  r_we_n  <= 1'b0;
                  r_cnt   <= C_ONE;
                  r_state <= S_STROBE;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_STROBE: begin
               if (w_strobe_ok || w_to) begin
                  r_we_n  <= 1'b1;
                  r_cnt   <= C_ONE;
                  r_state <= S_HOLD;
                  // Set wins over a simultaneous err_clr (later NBA).
                  if (!w_strobe_ok) r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_HOLD: begin
               if (r_cnt >= C_HOLD) begin
                  r_cnt <= C_ONE;
                  if (r_phase) begin
                     r_sh[r_idx] <= r_dbyte[5:0];
                     r_sv[r_idx] <= 1'b1;
                  end
                  if (r_pend) begin
                     r_data  <= r_dbyte;
                     r_pend  <= 1'b0;
                     r_phase <= 1'b1;
                     r_state <= S_SETUP;
                  end else begin
                     r_ce_n     <= 1'b1;
                     r_in_ready <= 1'b1;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign psg_data    = r_data;
   assign psg_ce_n    = r_ce_n;
   assign psg_we_n    = r_we_n;
   assign busy        = r_busy;
   assign done        = r_done;
   assign timeout_err = r_err;

endmodule

// File: tb/tb_sn76489_bus_writer.sv
// Bench for sn76489_bus_writer: vector table of register writes with a
// byte scoreboard fed by a bus monitor and a configurable READY model.
module tb_sn76489_bus_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_reg = 3'd0;
   logic [9:0] in_value = 10'd0;
   logic [7:0] psg_data;
   logic       psg_ce_n;
   logic       psg_we_n;
   logic       psg_ready = 1'b1;
   logic       busy;
   logic       done;
   logic       timeout_err;
   logic       err_clr = 1'b0;

   sn76489_bus_writer dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_reg      (in_reg),
      .in_value    (in_value),
      .psg_data    (psg_data),
      .psg_ce_n    (psg_ce_n),
      .psg_we_n    (psg_we_n),
      .psg_ready   (psg_ready),
      .busy        (busy),
      .done        (done),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   initial forever #5 clk = ~clk;

   typedef struct {
      logic [2:0] r;
      logic [9:0] v;
      int         n;
      logic [7:0] b0;
      logic [7:0] b1;
      int         wlen;
      int         mode;
      logic       err;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb[$];
   int         mode = 0;
   int         exp_len = 4;
   bit         skip_rise = 1'b0;
   int         wl = 0;
   logic       prev_we = 1'b1;
   logic [7:0] cap = 8'h00;
   int         ce_gap = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Bus monitor, scoreboard pop and READY model.
   always @(negedge clk) begin
      if (psg_we_n == 1'b0) begin
         if (prev_we == 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %02h with none queued",
                        psg_data);
            end else begin
               check("byte", {24'd0, psg_data}, {24'd0, sb.pop_front()});
            end
            check("ce_at_we", {31'd0, psg_ce_n}, 32'd0);
            cap = psg_data;
         end
         wl++;
      end else if (prev_we == 1'b0) begin
         if (!skip_rise) begin
            check("we_len", wl, exp_len);
            check("data_stable", {24'd0, psg_data}, {24'd0, cap});
         end
         wl = 0;
      end
      if (busy === 1'b1 && psg_ce_n === 1'b1) ce_gap++;
      prev_we = psg_we_n;
      case (mode)
         0: psg_ready = 1'b1;
         1: psg_ready = 1'b0;
         default: psg_ready = !(wl >= 2 && wl < 34);
      endcase
   end

   task automatic send(input logic [2:0] r, input logic [9:0] v);
      @(negedge clk);
      in_reg   = r;
      in_value = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_reg   = 3'($urandom);
      in_value = 10'($urandom);
      check("accept_state", {30'd0, in_ready, busy}, 32'b01);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t t);
      bit ok;
      int gap0;
      mode    = t.mode;
      exp_len = t.wlen;
      repeat (3) @(negedge clk);
      sb.push_back(t.b0);
      if (t.n == 2) sb.push_back(t.b1);
      gap0 = ce_gap;
      send(t.r, t.v);
      wait_done(400, ok);
      check("done_seen", {31'd0, ok}, 32'd1);
      check("idle_ce_n", {31'd0, psg_ce_n}, 32'd1);
      check("idle_ready", {31'd0, in_ready}, 32'd1);
      check("sb_drained", sb.size(), 32'd0);
      check("ce_gap", ce_gap - gap0, 32'd0);
      check("tmo_err", {31'd0, timeout_err}, {31'd0, t.err});
      @(negedge clk);
      check("done_pulse", {31'd0, done}, 32'd0);
   endtask

   vec_t tbl[13];

   initial begin
      bit ok;
      tbl[0]  = '{3'd0, 10'h3A5, 2, 8'h85, 8'h3A, 4, 0, 1'b0};
      tbl[1]  = '{3'd7, 10'h00F, 1, 8'hFF, 8'h00, 4, 0, 1'b0};
      tbl[2]  = '{3'd6, 10'h00D, 1, 8'hE5, 8'h00, 4, 0, 1'b0};
      tbl[3]  = '{3'd2, 10'h155, 2, 8'hA5, 8'h15, 4, 0, 1'b0};
      tbl[4]  = '{3'd2, 10'h15A, 1, 8'hAA, 8'h00, 4, 0, 1'b0};
      tbl[5]  = '{3'd2, 10'h25A, 2, 8'hAA, 8'h25, 4, 0, 1'b0};
      tbl[6]  = '{3'd1, 10'h3F3, 1, 8'h93, 8'h00, 4, 0, 1'b0};
      tbl[7]  = '{3'd4, 10'h000, 2, 8'hC0, 8'h00, 4, 0, 1'b0};
      tbl[8]  = '{3'd4, 10'h00F, 1, 8'hCF, 8'h00, 4, 0, 1'b0};
      tbl[9]  = '{3'd3, 10'h005, 1, 8'hB5, 8'h00, 4, 0, 1'b0};
      tbl[10] = '{3'd0, 10'h3A5, 2, 8'h85, 8'h3A, 4, 0, 1'b0};
      tbl[11] = '{3'd7, 10'h001, 1, 8'hF1, 8'h00, 36, 2, 1'b0};
      tbl[12] = '{3'd5, 10'h008, 1, 8'hD8, 8'h00, 64, 1, 1'b1};

      repeat (3) @(negedge clk);
      check("rst_data", {24'd0, psg_data}, 32'h00);
      check("rst_ctl", {26'd0, psg_ce_n, psg_we_n, in_ready, busy, done,
                        timeout_err}, 32'b111000);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // Reset during the first byte's strobe of a tone write.
      skip_rise = 1'b1;
      repeat (3) @(negedge clk);
      sb.push_back(8'h85);
      send(3'd0, 10'h0F5);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (psg_we_n == 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("strobe_reached", {31'd0, ok}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_data", {24'd0, psg_data}, 32'h00);
      check("abort_ctl", {28'd0, psg_we_n, psg_ce_n, in_ready, busy},
            32'b1110);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      check("abort_sb", sb.size(), 32'd0);
      skip_rise = 1'b0;

      // Shadow cleared by reset: full two-byte write again.
      run_vec(tbl[10]);
      run_vec(tbl[11]);
      run_vec(tbl[12]);

      mode = 0;
      repeat (10) @(negedge clk);
      check("err_sticky", {31'd0, timeout_err}, 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      @(negedge clk);
      check("err_cleared", {31'd0, timeout_err}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
